// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Read-side master for the team's synchronous FIFO. It drains the FIFO through
// its r_en / empty / registered data_out port and presents the words on a
// valid/ready output stream. A 3-entry prefetch buffer hides the FIFO's
// one-cycle read latency, so a sink that is always ready gets one word per cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          read enable; low stops new FIFO reads (buffered words still drain)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO data_out, valid the cycle after an accepted read
//   fifo_r_en   FIFO read request
//   m_valid     output word valid
//   m_ready     sink ready
//   m_data      output word (buffer head)
//   m_last      last word of the current PKT_LEN-word packet
//   word_count  words delivered since reset, wraps modulo 2^CNT_WIDTH
//   busy        buffer non-empty or a FIFO read in flight

module fifo_stream_reader #(
  parameter int DATASIZE  = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATASIZE-1:0]  fifo_data,
  output logic                 fifo_r_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATASIZE-1:0]  m_data,
  output logic                 m_last,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy
);

  // A 1-bit packet index is kept even for PKT_LEN=1; it then never leaves 0.
  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PKT_W-1:0] PKT_MAX = PKT_W'(PKT_LEN - 1);

  logic [DATASIZE-1:0] buf_mem [3];
  logic [1:0]          head;
  logic [1:0]          tail;
  logic [1:0]          buf_cnt;
  logic                inflight;
  logic [PKT_W-1:0]    pkt_idx;
  logic [2:0]          occupancy;
  logic                push;
  logic                pop;

  // Circular index advance over the three buffer slots.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Buffered words plus the one possibly in flight must never exceed the
  // buffer depth, which is what keeps the buffer from overflowing. The read is
  // deliberately independent of m_ready so the request path stays short.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};
  assign fifo_r_en = en & ~fifo_empty & (occupancy < 3'd3) & ~rst;

  assign push       = inflight;
  assign pop        = m_valid & m_ready;
  assign m_valid    = (buf_cnt != 2'd0);
  assign m_data     = buf_mem[head];
  assign m_last     = m_valid & (pkt_idx == PKT_MAX);
  assign busy       = m_valid | inflight;

  // Buffer storage has no reset; its contents are only visible through the
  // head index while buf_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_mem[tail] <= fifo_data;
    end
  end

  // Control state: in-flight flag, buffer indices/count, packet position and
  // the delivered-word counter. A push and a pop on the same edge leave the
  // count unchanged. Reset drops any in-flight word, so the data_out that
  // arrives right after reset is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      head       <= 2'd0;
      tail       <= 2'd0;
      buf_cnt    <= 2'd0;
      pkt_idx    <= '0;
      word_count <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (push) begin
        tail <= next_idx(tail);
      end
      if (pop) begin
        head       <= next_idx(head);
        pkt_idx    <= (pkt_idx == PKT_MAX) ? '0 : pkt_idx + PKT_W'(1);
        word_count <= word_count + CNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Drives two readers from one FIFO model: the default configuration and a
// CNT_WIDTH=4 / PKT_LEN=1 configuration sharing every input. A queue-based
// model of what has been read but not yet delivered predicts every output on
// every falling edge; directed scenarios add literal expectations.

module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       m_ready;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;

  logic        r_en, m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [15:0] word_count;

  logic        w_r_en, w_valid, w_last, w_busy;
  logic [7:0]  w_data;
  logic [3:0]  w_count;

  logic [7:0] fifo_q [$];
  logic [7:0] exp_q  [$];
  bit         m_inflight = 1'b0;
  int         pkt_pos    = 0;
  int         m_count    = 0;
  int         reads_total = 0;
  bit         started    = 1'b0;

  int checks   = 0;
  int failures = 0;
  int base;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATASIZE(8), .PKT_LEN(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .word_count(word_count), .busy(busy)
  );

  fifo_stream_reader #(.DATASIZE(8), .PKT_LEN(1), .CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(w_r_en), .m_valid(w_valid), .m_ready(m_ready), .m_data(w_data),
    .m_last(w_last), .word_count(w_count), .busy(w_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles, input logic en_v, input logic ready_v);
    en      = en_v;
    m_ready = ready_v;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [7:0] d);
    fifo_q.push_back(d);
  endtask

  // FIFO model with registered data_out and empty flag, plus the reference
  // model: exp_q holds every word read from the FIFO and captured but not yet
  // delivered, in order. Everything is evaluated on pre-edge values.
  always @(posedge clk) begin
    bit want;
    want = en && !fifo_empty && ((exp_q.size() + int'(m_inflight)) < 3) && !rst;
    if (r_en) begin
      reads_total++;
      if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (rst) begin
      exp_q.delete();
      m_inflight = 1'b0;
      pkt_pos    = 0;
      m_count    = 0;
    end else begin
      if (exp_q.size() != 0 && m_ready) begin
        void'(exp_q.pop_front());
        pkt_pos = (pkt_pos + 1) % 4;
        m_count++;
      end
      if (m_inflight) exp_q.push_back(fifo_data);
      m_inflight = want;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int  occ;
    bit  ev;
    bit  er;
    if (started) begin
      occ = exp_q.size() + int'(m_inflight);
      ev  = (exp_q.size() != 0);
      er  = en && !fifo_empty && (occ < 3) && !rst;
      checkOutput("fifo_r_en", 32'(r_en), 32'(er));
      checkOutput("m_valid", 32'(m_valid), 32'(ev));
      checkOutput("busy", 32'(busy), 32'(occ != 0));
      checkOutput("word_count", 32'(word_count), 32'(16'(m_count)));
      checkOutput("w_fifo_r_en", 32'(w_r_en), 32'(er));
      checkOutput("w_m_valid", 32'(w_valid), 32'(ev));
      checkOutput("w_busy", 32'(w_busy), 32'(occ != 0));
      checkOutput("w_word_count", 32'(w_count), 32'(m_count % 16));
      if (ev) begin
        checkOutput("m_data", 32'(m_data), 32'(exp_q[0]));
        checkOutput("m_last", 32'(m_last), 32'(pkt_pos == 3));
        checkOutput("w_m_data", 32'(w_data), 32'(exp_q[0]));
        checkOutput("w_m_last", 32'(w_last), 32'd1);
      end else begin
        checkOutput("m_last_idle", 32'(m_last), 32'd0);
        checkOutput("w_m_last_idle", 32'(w_last), 32'd0);
      end
    end
  end

  // Directed scenarios followed by a randomized run and the counter wrap.
  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    checkOutput("reset_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_count", 32'(word_count), 32'd0);
    checkOutput("reset_r_en", 32'(r_en), 32'd0);

    // Streaming 0x01..0x08 with a permanently ready sink.
    for (int i = 1; i <= 8; i++) pushWord(8'(i));
    applyStimulus(1, 1'b0, 1'b1);
    base = reads_total;
    applyStimulus(1, 1'b1, 1'b1);
    checkOutput("stream_lat1_valid", 32'(m_valid), 32'd0);
    applyStimulus(1, 1'b1, 1'b1);
    checkOutput("stream_lat2_valid", 32'(m_valid), 32'd1);
    checkOutput("stream_first_data", 32'(m_data), 32'h01);
    applyStimulus(10, 1'b1, 1'b1);
    checkOutput("stream_reads", 32'(reads_total - base), 32'd8);
    checkOutput("stream_count", 32'(word_count), 32'd8);
    checkOutput("stream_busy", 32'(busy), 32'd0);

    // Backpressure: only three reads while the sink stalls.
    for (int i = 0; i < 6; i++) pushWord(8'(8'h10 + i));
    base = reads_total;
    applyStimulus(10, 1'b1, 1'b0);
    checkOutput("bp_reads", 32'(reads_total - base), 32'd3);
    checkOutput("bp_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_data", 32'(m_data), 32'h10);
    checkOutput("bp_r_en", 32'(r_en), 32'd0);
    applyStimulus(12, 1'b1, 1'b1);
    checkOutput("bp_count", 32'(word_count), 32'd14);

    // Empty boundary: single word, then a late write.
    pushWord(8'hAA);
    applyStimulus(6, 1'b1, 1'b1);
    checkOutput("empty_valid", 32'(m_valid), 32'd0);
    checkOutput("empty_r_en", 32'(r_en), 32'd0);
    pushWord(8'hBB);
    applyStimulus(1, 1'b1, 1'b1);
    checkOutput("empty_resume_r_en", 32'(r_en), 32'd1);
    applyStimulus(2, 1'b1, 1'b1);
    checkOutput("empty_bb_data", 32'(m_data), 32'hBB);
    applyStimulus(2, 1'b1, 1'b1);
    checkOutput("empty_count", 32'(word_count), 32'd16);

    // Enable gating: en drops right after one read issue.
    for (int i = 0; i < 5; i++) pushWord(8'(8'hC0 + i));
    applyStimulus(1, 1'b0, 1'b1);
    base = reads_total;
    applyStimulus(1, 1'b1, 1'b1);
    applyStimulus(6, 1'b0, 1'b1);
    checkOutput("gate_reads", 32'(reads_total - base), 32'd1);
    checkOutput("gate_count", 32'(word_count), 32'd17);
    applyStimulus(10, 1'b1, 1'b1);
    checkOutput("gate_final_count", 32'(word_count), 32'd21);

    // Reset with two buffered words and one in flight.
    for (int i = 0; i < 5; i++) pushWord(8'(8'hE0 + i));
    base = reads_total;
    applyStimulus(4, 1'b1, 1'b0);
    checkOutput("mid_reads", 32'(reads_total - base), 32'd3);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_head", 32'(m_data), 32'hE0);
    rst = 1'b1;
    applyStimulus(1, 1'b1, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_count", 32'(word_count), 32'd0);
    applyStimulus(8, 1'b1, 1'b1);
    checkOutput("mid_after_count", 32'(word_count), 32'd2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) pushWord(8'($urandom));
      applyStimulus(1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    rst = 1'b0;
    applyStimulus(200, 1'b1, 1'b1);

    // Counter wrap on the 4-bit instance: 17 words after a clean reset.
    rst = 1'b1;
    fifo_q.delete();
    applyStimulus(2, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) pushWord(8'(8'h40 + i));
    applyStimulus(30, 1'b1, 1'b1);
    checkOutput("wrap_w_count", 32'(w_count), 32'd1);
    checkOutput("wrap_count", 32'(word_count), 32'd17);
    checkOutput("wrap_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
